// File: rtl/seq_check_ctrl.sv
// -----------------------------------------------------------------------------
// seq_check_ctrl
//
// Frame controller for the serial "at least three 0s and one 1" sequence
// checker. It accepts a parallel frame, clears the checker for one cycle, and
// then feeds the frame to the checker one bit per cycle. It captures the verdict
// and the transmit-order position of the bit that completed the check, and
// returns them on a valid/ready result channel. It also keeps saturating
// frame and pass counters.
//
// Parameters
//   FRAME_W    bits per frame (2..32)
//   MSB_FIRST  1: bit FRAME_W-1 is sent first, 0: bit 0 is sent first
//
// Ports
//   clk, rst          rising-edge clock, synchronous active-high reset
//   frm_valid/ready   frame handshake; frm_ready is high only in IDLE
//   frm_data          frame bits, captured on the frame handshake
//   chk_state_reset   drives the checker's in_state_reset
//   chk_data          drives the checker's in_data
//   chk_out           checker's Moore output (1 in its accepting state)
//   res_valid/ready   result handshake
//   res_pass          frame satisfied the check
//   res_bitpos        transmit-order index of the completing bit (0 on fail)
//   frame_cnt         frames completed, saturating at 16'hFFFF
//   pass_cnt          frames passed, saturating at 16'hFFFF
//
// Optional feature macro: SEQ_CHECK_CTRL_EARLY_EXIT_EN
//   When defined, the first hit seen while shifting ends the frame immediately
//   and the remaining bits are not sent. res_pass and res_bitpos are the same
//   as in the default build; only the latency of passing frames changes.
// -----------------------------------------------------------------------------
module seq_check_ctrl #(
  parameter int FRAME_W   = 8,
  parameter int MSB_FIRST = 1,
  localparam int BP_W     = $clog2(FRAME_W)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frm_valid,
  output logic               frm_ready,
  input  logic [FRAME_W-1:0] frm_data,
  output logic               chk_state_reset,
  output logic               chk_data,
  input  logic               chk_out,
  output logic               res_valid,
  input  logic               res_ready,
  output logic               res_pass,
  output logic [BP_W-1:0]    res_bitpos,
  output logic [15:0]        frame_cnt,
  output logic [15:0]        pass_cnt
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    SHIFT  = 3'd2,
    SAMPLE = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam logic [BP_W-1:0] K_LAST = BP_W'(FRAME_W - 1);

  state_t               state;
  state_t               state_nxt;

  logic [FRAME_W-1:0]   sr;
  logic [FRAME_W-1:0]   sr_shifted;
  logic                 head;
  logic [BP_W-1:0]      k;
  logic                 hit;
  logic [BP_W-1:0]      hit_pos;

  logic                 load;
  logic                 shift_en;
  logic                 rec_hit;
  logic                 finish;
  logic                 finish_pass;
  logic [BP_W-1:0]      finish_pos;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Head bit of the shift register and the register after one shift,
  // according to the transmit order.
  always_comb begin
    if (MSB_FIRST != 0) begin
      head       = sr[FRAME_W-1];
      sr_shifted = {sr[FRAME_W-2:0], 1'b0};
    end else begin
      head       = sr[0];
      sr_shifted = {1'b0, sr[FRAME_W-1:1]};
    end
  end

  always_comb begin
    state_nxt       = state;
    frm_ready       = 1'b0;
    chk_state_reset = 1'b0;
    chk_data        = 1'b0;
    res_valid       = 1'b0;
    load            = 1'b0;
    shift_en        = 1'b0;
    rec_hit         = 1'b0;
    finish          = 1'b0;
    finish_pass     = 1'b0;
    finish_pos      = '0;

    case (state)
      IDLE: begin
        frm_ready = 1'b1;
        if (frm_valid) begin
          load      = 1'b1;
          state_nxt = CLEAR;
        end
      end

      CLEAR: begin
        chk_state_reset = 1'b1;
        state_nxt       = SHIFT;
      end

      SHIFT: begin
        chk_data = head;
        shift_en = 1'b1;
        if (k == K_LAST) begin
          state_nxt = SAMPLE;
        end
        // At k=0 chk_out still reflects the cycle before the first bit, so
        // only k>=1 can carry a real verdict (covering bits 0..k-1).
        if ((k != '0) && chk_out && !hit) begin
`ifdef SEQ_CHECK_CTRL_EARLY_EXIT_EN
          finish      = 1'b1;
          finish_pass = 1'b1;
          finish_pos  = k - BP_W'(1);
          state_nxt   = DONE;
`else
          rec_hit     = 1'b1;
`endif
        end
      end

      SAMPLE: begin
        // chk_out now covers the whole frame; a hit seen only here was
        // completed by the last transmitted bit.
        finish      = 1'b1;
        finish_pass = hit | chk_out;
        if (hit) begin
          finish_pos = hit_pos;
        end else if (chk_out) begin
          finish_pos = K_LAST;
        end
        state_nxt = DONE;
      end

      DONE: begin
        res_valid = 1'b1;
        if (res_ready) begin
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Control: state, bit counter, hit flag, result and statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      k          <= '0;
      hit        <= 1'b0;
      res_pass   <= 1'b0;
      res_bitpos <= '0;
      frame_cnt  <= 16'd0;
      pass_cnt   <= 16'd0;
    end else begin
      state <= state_nxt;
      if (load) begin
        k   <= '0;
        hit <= 1'b0;
      end else if (shift_en) begin
        k <= k + BP_W'(1);
      end
      if (rec_hit) begin
        hit <= 1'b1;
      end
      if (finish) begin
        res_pass   <= finish_pass;
        res_bitpos <= finish_pos;
        frame_cnt  <= sat_inc(frame_cnt);
        if (finish_pass) begin
          pass_cnt <= sat_inc(pass_cnt);
        end
      end
    end
  end

  // Data: frame shift register and recorded hit position (only read while
  // the hit flag is set, so they need no reset).
  always_ff @(posedge clk) begin
    if (load) begin
      sr <= frm_data;
    end else if (shift_en) begin
      sr <= sr_shifted;
    end
    if (rec_hit) begin
      hit_pos <= k - BP_W'(1);
    end
  end

endmodule

// File: doc/seq_check_ctrl.md
# seq_check_ctrl

Frame controller for the serial sequence-checker FSM (the "at least three 0s and one 1" detector with `in_data`, `in_state_reset` and `out`). It accepts parallel frames over a valid/ready handshake and clears the checker before each frame. It then feeds the frame to the checker one bit per cycle, captures the verdict and first-hit bit position, and returns them on a valid/ready result channel. It also keeps frame and pass statistics.

## Interface
- `FRAME_W`, default 8: bits per frame, legal range 2..32.
- `MSB_FIRST`, default 1: 1 sends bit `FRAME_W-1` first; 0 sends bit 0 first.
- `clk`  in  1  the only clock; everything is on its rising edge.
- `rst`  in  1  synchronous, active-high reset, sampled on `clk`.
- `frm_valid`  in  1  a frame is offered.
- `frm_ready`  out  1  high only in IDLE.
- `frm_data`  in  FRAME_W  frame bits; captured on handshake.
- `chk_state_reset`  out  1  drives the checker's `in_state_reset`.
- `chk_data`  out  1  drives the checker's `in_data`.
- `chk_out`  in  1  checker's Moore output: 1 when the checker state is s7.
- `res_valid`  out  1  a result is available.
- `res_ready`  in  1  downstream accepts the result.
- `res_pass`  out  1  the frame satisfied the check.
- `res_bitpos`  out  $clog2(FRAME_W)  transmit-order index of the bit that completed the check; 0 when `res_pass`=0.
- `frame_cnt`  out  16  frames completed; saturates at 16'hFFFF.
- `pass_cnt`  out  16  frames that passed; saturates at 16'hFFFF.

## Operation
- State machine states: IDLE, CLEAR, SHIFT, SAMPLE, DONE.
- **IDLE**
  - `frm_ready`=1.
  - When `frm_valid`=1, load `frm_data` into the shift register, clear the hit flag and bit counter `k`, and go to CLEAR.
- **CLEAR** (1 cycle)
  - `chk_state_reset`=1, `chk_data`=0.
  - Go to SHIFT with `k`=0.
- **SHIFT** (cycle for bit `k`)
  - `chk_data` = current head bit of the shift register; `chk_state_reset`=0.
  - In this cycle, `chk_out` reflects bits 0..k-1.
  - If `k`≥1, `chk_out`=1 and the hit flag is clear: set the hit flag and record position `k-1`.
  - Shift the register and increment `k`.
  - After `k`=FRAME_W-1, go to SAMPLE.
- **SAMPLE** (1 cycle)
  - `chk_out` now reflects the full frame.
  - If `chk_out`=1 and no hit has been recorded, record position FRAME_W-1.
  - `res_pass` = hit flag OR `chk_out`.
  - Update the counters and go to DONE.
- **DONE**
  - `res_valid`=1; `res_pass` and `res_bitpos` are held stable.
  - When `res_ready`=1, go to IDLE.
- `frm_valid` is ignored outside IDLE; `frm_data` is not re-sampled after the handshake.
- Counters
  - `frame_cnt` increments by 1 per completed frame.
  - `pass_cnt` increments by 1 when the frame passes.
  - Both saturate and never wrap.
- `chk_out` is ignored in IDLE, CLEAR, DONE and at `k`=0, because it is stale in those cycles.

## Timing
- Handshake cycle = cycle 0.
  - CLEAR is cycle 1.
  - SHIFT runs cycles 2..FRAME_W+1.
  - SAMPLE is cycle FRAME_W+2.
  - `res_valid` rises at cycle FRAME_W+3.
- With `res_ready` held at 1:
  - `frm_ready` returns at cycle FRAME_W+4.
  - Throughput is one frame per FRAME_W+4 cycles.
- The result handshake completes in DONE; `res_valid` drops the following cycle.
- Reset values:
  - State = IDLE.
  - `frm_ready`=1 from the first cycle after reset.
  - `chk_state_reset`=0, `chk_data`=0.
  - `res_valid`=0, `res_pass`=0, `res_bitpos`=0.
  - `frame_cnt`=0, `pass_cnt`=0.
- `rst` asserted mid-frame (any state):
  - The next cycle is IDLE with all reset values.
  - The partial frame is dropped and not counted.
  - The checker is cleared again by the CLEAR cycle of the next frame.
- Backpressure: while in DONE with `res_ready`=0, all outputs are frozen for as long as it takes.
- Counter saturation: at 16'hFFFF, counting is suppressed and the value holds.

## Configuration
- Feature macro: `SEQ_CHECK_CTRL_EARLY_EXIT_EN`.
- Defined:
  - In SHIFT, the first cycle with `k`≥1 and `chk_out`=1 jumps directly to DONE.
  - The counters are updated on that jump; remaining bits are not sent.
  - `res_valid` rises at cycle 3+h, where h = `res_bitpos`+1.
  - A fail still takes the full FRAME_W+3 cycles.
- Undefined: every frame is shifted fully; latency is always FRAME_W+3.
- `res_pass` and `res_bitpos` are identical in both builds.

## Test plan
All scenarios use `FRAME_W`=8, `MSB_FIRST`=1 and an attached checker.

1. **Pass, three zeros then a one**
   - Stimulus: frame 8'h10 (bits 0,0,0,1,...).
   - Response: `res_pass`=1, `res_bitpos`=3.
   - `res_valid` at cycle 11, or at cycle 7 with EARLY_EXIT.
2. **Fail, all ones**
   - Stimulus: frame 8'hFF.
   - Response: `res_pass`=0, `res_bitpos`=0, `res_valid` at cycle 11 in both builds.
   - `chk_state_reset` is high exactly in cycle 1.
3. **Pass, a one then zeros**
   - Stimulus: frame 8'h80 (s1→s4→s5→s7).
   - Response: `res_pass`=1, `res_bitpos`=3.
   - Frame 8'h0F gives `res_pass`=1, `res_bitpos`=4.
4. **Backpressure**
   - Stimulus: hold `res_ready`=0 for 5 cycles after `res_valid`, and drive `frm_valid`=1 throughout.
   - Response: `res_valid`, `res_pass` and `res_bitpos` stay stable; `frm_ready`=0.
   - The handshake completes the cycle `res_ready`=1; the next frame is accepted one cycle later.
5. **Reset mid-frame**
   - Stimulus: assert `rst` at cycle 5 of frame 8'h10.
   - Response: next cycle all outputs equal their reset values and `frame_cnt`=0.
   - A following 8'h10 frame completes normally with `res_bitpos`=3.
6. **Back-to-back statistics**
   - Stimulus: frames 8'h10, 8'hFF, 8'h80 sent back-to-back with `res_ready`=1.
   - Response: `frame_cnt`=3, `pass_cnt`=2.
   - Preload the counters to 16'hFFFF via force, then send one more pass: both counters hold at 16'hFFFF.
